// File: rtl/idma_burst_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumCh frontends.
// Accepted bursts are tagged in an in-order FIFO so completions route back to their owner.
module idma_burst_arbiter #(
  parameter type         burst_req_t = logic,
  parameter int unsigned NumCh       = 4,
  parameter int unsigned MaxInFlight = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  burst_req_t [NumCh-1:0]             req_i,
  input  logic [NumCh-1:0]                   valid_i,
  output logic [NumCh-1:0]                   ready_o,
  output burst_req_t                         burst_req_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  input  logic                               trans_complete_i,
  output logic [NumCh-1:0]                   complete_o,
  output logic [NumCh-1:0]                   busy_o,
  output logic [$clog2(MaxInFlight+1)-1:0]   in_flight_o,
  output logic                               idle_o,
  output logic                               err_o
);

  localparam int unsigned ChW  = $clog2(NumCh);
  localparam int unsigned PtrW = $clog2(MaxInFlight);
  localparam int unsigned CntW = $clog2(MaxInFlight + 1);

  logic [ChW-1:0]  prio_q, prio_d;
  logic [ChW-1:0]  locked_ch_q, locked_ch_d;
  logic            locked_q, locked_d;
  logic            full_q, full_d;
  logic            err_q, err_d;
  logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
  logic [ChW-1:0]  tag_q [MaxInFlight];
  logic [ChW-1:0]  tag_d [MaxInFlight];
  logic [CntW-1:0] cnt_q [NumCh];
  logic [CntW-1:0] cnt_d [NumCh];

  logic [ChW-1:0]  winner;
  logic [ChW-1:0]  head;
  logic            found;
  int              scan_idx;
  logic            any_valid;
  logic            empty;
  logic            push;
  logic            pop;

  // A locked channel keeps the grant until its handshake, regardless of the scan.
  always_comb begin
    winner   = prio_q;
    found    = 1'b0;
    scan_idx = 0;
    if (locked_q) begin
      winner = locked_ch_q;
    end else begin
      for (int k = 0; k < int'(NumCh); k++) begin
        scan_idx = int'(prio_q) + k;
        if (scan_idx >= int'(NumCh)) scan_idx = scan_idx - int'(NumCh);
        if (!found && valid_i[ChW'(scan_idx)]) begin
          found  = 1'b1;
          winner = ChW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    any_valid = |valid_i;
    empty     = (wr_ptr_q == rd_ptr_q);
    head      = tag_q[rd_ptr_q[PtrW-1:0]];

    valid_o = any_valid && !full_q;
    push    = valid_o && ready_i;
    pop     = trans_complete_i && !empty;

    ready_o = '0;
    if (ready_i && !full_q) ready_o[winner] = 1'b1;

    burst_req_o = '0;
    if (valid_o) burst_req_o = req_i[winner];

    complete_o = '0;
    if (pop) complete_o[head] = 1'b1;

    tag_d = tag_q;
    if (push) tag_d[wr_ptr_q[PtrW-1:0]] = winner;

    wr_ptr_d = push ? wr_ptr_q + (PtrW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (PtrW+1)'(1) : rd_ptr_q;
    full_d   = (wr_ptr_d[PtrW] != rd_ptr_d[PtrW]) &&
               (wr_ptr_d[PtrW-1:0] == rd_ptr_d[PtrW-1:0]);

    prio_d      = prio_q;
    locked_d    = locked_q;
    locked_ch_d = locked_ch_q;
    if (push) begin
      prio_d   = (winner == ChW'(NumCh - 1)) ? '0 : winner + ChW'(1);
      locked_d = 1'b0;
    end else if (valid_o) begin
      locked_d    = 1'b1;
      locked_ch_d = winner;
    end

    err_d = err_q || (trans_complete_i && empty);

    // Same-channel push and pop cancel out and leave the count untouched.
    for (int i = 0; i < int'(NumCh); i++) begin
      cnt_d[i] = cnt_q[i];
      if (push && winner == ChW'(i)) cnt_d[i] = cnt_d[i] + CntW'(1);
      if (pop && head == ChW'(i))    cnt_d[i] = cnt_d[i] - CntW'(1);
      busy_o[i] = (cnt_q[i] != '0);
    end

    in_flight_o = wr_ptr_q - rd_ptr_q;
    idle_o      = (in_flight_o == '0) && !any_valid;
    err_o       = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= '0;
      locked_q    <= 1'b0;
      locked_ch_q <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < int'(MaxInFlight); i++) tag_q[i] <= '0;
      for (int i = 0; i < int'(NumCh); i++)       cnt_q[i] <= '0;
    end else begin
      prio_q      <= prio_d;
      locked_q    <= locked_d;
      locked_ch_q <= locked_ch_d;
      full_q      <= full_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      for (int i = 0; i < int'(MaxInFlight); i++) tag_q[i] <= tag_d[i];
      for (int i = 0; i < int'(NumCh); i++)       cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: doc/idma_burst_arbiter.md
# idma_burst_arbiter

Round-robin arbiter sharing one iDMA backend between `NumCh` frontends (e.g. several register frontends or descriptor engines). It forwards one burst request at a time to the backend and records the issuing channel of every accepted burst in an in-order tag FIFO. Each backend `trans_complete_i` pulse is routed back to the channel that owns the oldest outstanding burst. It sits between the frontends' `burst_req_o/valid_o/ready_i` and the backend request port.

## Interface
- `burst_req_t`, default `logic`: backend burst request type, passed through unmodified.
- `NumCh`, default 4: number of requesting channels, 2..16.
- `MaxInFlight`, default 8: tag FIFO depth (max accepted, not yet completed bursts), power of two, ≥2.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  `NumCh` x `burst_req_t`  per-channel burst request.
- `valid_i`  in  `NumCh`  per-channel request valid.
- `ready_o`  out  `NumCh`  per-channel accept; one-hot or zero.
- `burst_req_o`  out  `burst_req_t`  request to backend.
- `valid_o`  out  1  request valid to backend.
- `ready_i`  in  1  backend accepts request.
- `trans_complete_i`  in  1  backend retired oldest burst (one-cycle pulse per burst).
- `complete_o`  out  `NumCh`  one-hot completion pulse to owning channel.
- `busy_o`  out  `NumCh`  channel has ≥1 outstanding burst.
- `in_flight_o`  out  `$clog2(MaxInFlight+1)`  FIFO occupancy.
- `idle_o`  out  1  no outstanding burst and no valid request.
- `err_o`  out  1  sticky: completion received with empty FIFO.

## Operation
- Round-robin pointer `prio` (`$clog2(NumCh)` bits): the winner is the first `i` with `valid_i[i]` scanning `prio, prio+1, …` modulo `NumCh`.
- Grant lock: when `valid_o && !ready_i`, the current winner is held in a registered `locked_ch`. It stays selected until its handshake completes, even if a lower-index channel raises valid. Channels must not drop `valid_i` before their own `ready_o`.
- `burst_req_o = req_i[winner]`. When `valid_o=0`, `burst_req_o = '0`.
- `valid_o = |valid_i && !full`. `ready_o[winner] = ready_i && !full`; all other bits are 0.
- Handshake (`valid_o && ready_i`):
  - push `winner` into the tag FIFO;
  - `prio <= winner+1` (wraps at `NumCh`);
  - increment `cnt[winner]`;
  - clear the lock.
- `full` is registered (`in_flight_o == MaxInFlight`). A pop in the same cycle does not enable a push; there is no path from `trans_complete_i` to `valid_o`.
- Completion (`trans_complete_i` and FIFO not empty):
  - `complete_o = onehot(head)` combinationally in the same cycle;
  - pop the head;
  - decrement `cnt[head]`.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. If the same channel is pushed and popped, `cnt` is unchanged.
- `trans_complete_i` with the FIFO empty: `complete_o = 0`, no pop, `err_o <= 1`. `err_o` is cleared only by reset.
- `busy_o[i] = cnt[i] != 0`. `cnt` width is `$clog2(MaxInFlight+1)`; it cannot overflow because FIFO depth bounds it.
- `idle_o = (in_flight_o == 0) && !(|valid_i)`.

## Timing
- Request path is zero-latency combinational: `valid_i` → `valid_o` and `ready_i` → `ready_o` in the same cycle.
- Completion path is zero-latency combinational: `trans_complete_i` → `complete_o`.
- Sustained throughput is one burst per cycle while `ready_i=1` and not full.
- Reset values (registered state): `prio=0`, lock clear, FIFO empty, all `cnt=0`, `err_o=0`.
- Outputs after reset: `in_flight_o=0`, `busy_o=0`, `full=0`.
- Combinational outputs after reset follow the inputs: `valid_o=|valid_i`, `ready_o` as above, `complete_o=0` (FIFO empty).
- Reset mid-operation:
  - all outstanding tags are discarded;
  - completions arriving after reset set `err_o`;
  - the integrator resets the backend in the same cycle.
- Pointer wrap: read and write pointers are `$clog2(MaxInFlight)` bits plus a wrap bit; full/empty are derived from the wrap-bit comparison.

## Test plan
- Fairness: `NumCh=4`, all four `valid_i` held high, `ready_i=1` for 8 cycles → grant order 0,1,2,3,0,1,2,3; `in_flight_o` climbs to 8 and `valid_o` drops in cycle 9.
- Lock under backpressure: ch2 valid with `ready_i=0` for 3 cycles, then ch0 raises valid → `burst_req_o` stays `req_i[2]`. Release `ready_i`: ch2 handshakes; the next grant is ch0 (scan from 3 wraps to 0).
- Completion routing: issue bursts from ch1, ch3, ch1, then pulse `trans_complete_i` 3 times → `complete_o` = 0010, 1000, 0010; `busy_o[1]` falls only after the third pulse.
- Full boundary: fill to `MaxInFlight=8`, then assert `trans_complete_i` with a pending request → no push that cycle; the push occurs next cycle; `in_flight_o` goes 8→7→8.
- Simultaneous push/pop: at occupancy 3, handshake and completion in the same cycle → `in_flight_o` stays 3 and the head tag advances.
- Error and reset: `trans_complete_i` with the FIFO empty → `complete_o=0` and `err_o=1` sticky. With 5 bursts in flight, assert `rst_i` → next cycle `in_flight_o=0`, `busy_o=0`, `err_o=0`, `prio=0`.
